// File: rtl/bexkat1Def.sv
// Shared definitions for the bexkat1 execute stage: ALU opcode encoding.
package bexkat1Def;

    // Opcodes 0..7 keep their original single-cycle encodings; 8..10 are the
    // carry-in and multi-cycle additions.
    typedef enum logic [3:0] {
        ALU_AND     = 4'd0,
        ALU_OR      = 4'd1,
        ALU_XOR     = 4'd2,
        ALU_ADD     = 4'd3,
        ALU_SUB     = 4'd4,
        ALU_LSHIFT  = 4'd5,
        ALU_RSHIFTA = 4'd6,
        ALU_RSHIFTL = 4'd7,
        ALU_ADC     = 4'd8,
        ALU_SBC     = 4'd9,
        ALU_MUL     = 4'd10
    } alu_t;

endpackage : bexkat1Def

// File: rtl/alu_mul_iter.sv
// Radix-2 shift-add unsigned multiplier: one multiplier bit per cycle,
// WIDTH iterations, done_o pulses for one cycle with the full product.
module alu_mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic                 done_o,
    output logic [2*WIDTH-1:0]   product_o
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0]   a_q;
    logic [2*WIDTH-1:0] prod_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               done_q;
    logic [WIDTH:0]     step_sum;

    // Conditionally add the multiplicand into the upper half, keeping its carry.
    assign step_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
                    + {1'b0, (prod_q[0] ? a_q : {WIDTH{1'b0}})};

    // Load operands on start, then shift-add one bit per cycle until cnt_q drains.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_q    <= '0;
            prod_q <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            // NOTE: clocked state uses non-blocking assignments so every flop
            // samples the pre-edge values regardless of statement order.
            done_q <= 1'b0;
            if (start_i) begin
                a_q    <= a_i;
                prod_q <= {{WIDTH{1'b0}}, b_i};
                cnt_q  <= CNT_W'(WIDTH);
            end else if (cnt_q != '0) begin
                prod_q <= {step_sum, prod_q[WIDTH-1:1]};
                cnt_q  <= cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign done_o    = done_q;
    assign product_o = prod_q;

endmodule : alu_mul_iter

// File: rtl/alu_mc.sv
// Multi-cycle integer ALU with valid/ready on both sides. Single-cycle ops
// complete on the accepting edge; MUL runs through the iterative multiplier.
module alu_mc
    import bexkat1Def::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [3:0]       func_i,
    input  logic [WIDTH-1:0] in1_i,
    input  logic [WIDTH-1:0] in2_i,
    input  logic             c_in_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_o,
    output logic             c_out_o,
    output logic             z_out_o,
    output logic             n_out_o,
    output logic             v_out_o
);

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t             state_q;
    logic               valid_q;
    logic [WIDTH-1:0]   out_q;
    logic               c_q, z_q, n_q, v_q;

    logic               accept;
    logic               is_mul;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_prod;

    logic [WIDTH-1:0]   res_d;
    logic               c_d, v_d;

    // Shift amount: low field plus an out-of-range flag from the upper bits.
    logic [SHAMT_W-1:0] s_lo;
    logic               s_oob, s_ge_w, s_gt_w;

    assign s_lo   = in2_i[SHAMT_W-1:0];
    assign s_oob  = |in2_i[WIDTH-1:SHAMT_W];
    assign s_ge_w = s_oob | (s_lo >= SHAMT_W'(WIDTH));
    assign s_gt_w = s_oob | (s_lo >  SHAMT_W'(WIDTH));

    assign in_ready_o = (state_q == S_IDLE) & (~valid_q | out_ready_i);
    assign accept     = in_valid_i & in_ready_o;
    assign is_mul     = (func_i == ALU_MUL);

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .start_i   (accept & is_mul),
        .a_i       (in1_i),
        .b_i       (in2_i),
        .done_o    (mul_done),
        .product_o (mul_prod)
    );

    // Single-cycle result and carry/overflow for the presented opcode.
    always_comb begin
        logic [WIDTH:0] wide;
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        wide  = '0;
        res_d = in1_i;
        c_d   = 1'b0;
        v_d   = 1'b0;
        case (func_i)
            ALU_AND: res_d = in1_i & in2_i;
            ALU_OR:  res_d = in1_i | in2_i;
            ALU_XOR: res_d = in1_i ^ in2_i;
            ALU_ADD, ALU_ADC: begin
                wide  = {1'b0, in1_i} + {1'b0, in2_i}
                      + (WIDTH+1)'((func_i == ALU_ADC) & c_in_i);
                res_d = wide[WIDTH-1:0];
                c_d   = wide[WIDTH];
                v_d   = (in1_i[WIDTH-1] == in2_i[WIDTH-1]) &
                        (res_d[WIDTH-1] != in1_i[WIDTH-1]);
            end
            ALU_SUB, ALU_SBC: begin
                // Top bit of the widened difference is the borrow.
                wide  = {1'b0, in1_i} - {1'b0, in2_i}
                      - (WIDTH+1)'((func_i == ALU_SBC) & c_in_i);
                res_d = wide[WIDTH-1:0];
                c_d   = wide[WIDTH];
                v_d   = (in1_i[WIDTH-1] != in2_i[WIDTH-1]) &
                        (res_d[WIDTH-1] != in1_i[WIDTH-1]);
            end
            ALU_LSHIFT: begin
                // Bit WIDTH of the widened shift is the last bit shifted out.
                wide  = {1'b0, in1_i} << s_lo;
                res_d = s_ge_w ? '0 : wide[WIDTH-1:0];
                c_d   = s_gt_w ? 1'b0 : wide[WIDTH];
                v_d   = res_d[WIDTH-1] ^ c_d;
            end
            ALU_RSHIFTL: res_d = s_ge_w ? '0 : (in1_i >> s_lo);
            ALU_RSHIFTA: res_d = s_ge_w ? {WIDTH{in1_i[WIDTH-1]}}
                                        : WIDTH'($signed(in1_i) >>> s_lo);
            default: res_d = in1_i;
        endcase
    end

    // Control FSM with registered result, flags and output valid.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
            out_q   <= '0;
            c_q     <= 1'b0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
            v_q     <= 1'b0;
        end else begin
            if (valid_q && out_ready_i) begin
                valid_q <= 1'b0;
            end
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        if (is_mul) begin
                            state_q <= S_MUL;
                        end else begin
                            valid_q <= 1'b1;
                            out_q   <= res_d;
                            c_q     <= c_d;
                            z_q     <= (res_d == '0);
                            n_q     <= res_d[WIDTH-1];
                            v_q     <= v_d;
                        end
                    end
                end
                S_MUL: begin
                    if (mul_done) begin
                        state_q <= S_IDLE;
                        valid_q <= 1'b1;
                        out_q   <= mul_prod[WIDTH-1:0];
                        c_q     <= |mul_prod[2*WIDTH-1:WIDTH];
                        z_q     <= (mul_prod[WIDTH-1:0] == '0);
                        n_q     <= mul_prod[WIDTH-1];
                        v_q     <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign out_valid_o = valid_q;
    assign out_o       = out_q;
    assign c_out_o     = c_q;
    assign z_out_o     = z_q;
    assign n_out_o     = n_q;
    assign v_out_o     = v_q;

endmodule : alu_mc

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised multi-cycle successor to the single-cycle integer ALU in the bexkat1 execute stage.
- Adds a valid/ready handshake on input and output, so the pipeline can stall on either side.
- Adds carry-in ops (ADC/SBC) and an iterative unsigned multiply (MUL).
- Flags are computed from the new result and registered together with it.

Parameters:
WIDTH, 32, datapath width in bits (must be >= 4)
SHAMT_W, $clog2(WIDTH)+1, width of the internal shift-amount compare (derived; do not override)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
in_valid_i  in  1  operation request valid
in_ready_o  out  1  block can accept an operation this cycle
func_i  in  4  alu_t opcode
in1_i  in  WIDTH  operand A
in2_i  in  WIDTH  operand B / shift amount
c_in_i  in  1  carry/borrow in (ADC, SBC only)
out_valid_o  out  1  result and flags valid
out_ready_i  in  1  consumer accepts the result
out_o  out  WIDTH  result
c_out_o  out  1  carry/borrow flag
z_out_o  out  1  zero flag (out_o == 0)
n_out_o  out  1  negative flag (out_o[WIDTH-1])
v_out_o  out  1  signed overflow flag

Behaviour:
- Reset (rst_ni low, async) values:
  - out_o=0, all flags=0, out_valid_o=0, state=IDLE, multiplier cleared.
  - in_ready_o reads 1 during reset; requests during reset are ignored.
- Handshake:
  - Accept on a clk_i edge with in_valid_i & in_ready_o.
  - in_ready_o = (state==IDLE) & (!out_valid_o | out_ready_i), combinational.
  - Result retires on a clk_i edge with out_valid_o & out_ready_i.
  - out_o and flags hold stable while out_valid_o=1 and out_ready_i=0.
- Latency and throughput:
  - Single-cycle ops: out_valid_o rises on the edge that accepts the op.
  - Back-to-back single-cycle ops sustain 1 op/cycle when out_ready_i=1.
- State machine: IDLE, MUL.
  - IDLE -> MUL when a MUL is accepted.
  - In MUL: radix-2 shift-add over a 2*WIDTH product register, one bit per cycle, WIDTH cycles.
  - On the final iteration, load the result, set out_valid_o, return to IDLE.
  - MUL latency: out_valid_o rises exactly WIDTH+1 edges after accept.
  - in_ready_o=0 throughout MUL.
- Ops and flags (all flags derived from the new result):
  - AND, OR, XOR: c=v=0.
  - ADD: c = carry out of bit WIDTH-1; v = standard two's-complement overflow.
  - ADC: in1+in2+c_in_i; c and v as ADD.
  - SUB: in1-in2; c = borrow (in1 < in2 unsigned); v = standard two's-complement overflow.
  - SBC: in1-in2-c_in_i; c = borrow including c_in_i.
  - LSHIFT: for shift amount s = in2 as unsigned, 1 <= s <= WIDTH: c = in1[WIDTH-s], else c=0; result = 0 if s >= WIDTH; v = n ^ c.
  - RSHIFTL: result 0 if s >= WIDTH; c=0; v=0.
  - RSHIFTA: result is all sign bits if s >= WIDTH; c=0; v=0.
  - MUL: low WIDTH bits of the unsigned product; c = |high half; v=0.
  - Undefined func codes: out=in1, c=v=0.
- z and n always follow the registered result.
- Reset mid-MUL aborts the operation; no partial result is ever presented.

Decomposition:
- bexkat1Def package:
  - Widen alu_t to 4 bits: AND=0, OR=1, XOR=2, ADD=3, SUB=4, LSHIFT=5, RSHIFTA=6, RSHIFTL=7, ADC=8, SBC=9, MUL=10.
  - Existing encodings are unchanged.
- The state enum stays local to alu_mc.
- One sub-module: alu_mul_iter, the iterative multiplier.
  - Ports: start, operands, done, product.
  - Same clock and reset as alu_mc.

Test Plan (WIDTH=32):
1. ADD 0x7FFFFFFF+0x00000001 -> out 0x80000000, n=1 v=1 c=0 z=0; out_valid_o on the accepting edge.
2. SUB 0x00000000-0x00000001 -> 0xFFFFFFFF, c=1 n=1 v=0. Then SBC 5-3 with c_in=1 -> 0x00000001, c=0.
3. Shifts:
   - LSHIFT 0x80000001 by 1 -> 0x00000002, c=1 v=1.
   - LSHIFT by 40 -> 0, c=0 z=1.
   - RSHIFTA 0x80000000 by 40 -> 0xFFFFFFFF.
4. MUL 0x00010000*0x00010000 -> out 0, c=1 z=1.
   - out_valid_o exactly 33 edges after accept.
   - in_ready_o=0 for the whole interval.
   - A request held during the MUL is not accepted early.
5. Back-pressure: out_ready_i=0, issue two ADDs (1+1, 2+2).
   - First result 2 stays stable; in_ready_o=0; second request is held.
   - Raise out_ready_i -> results 2 then 4 delivered in order, no loss or duplication.
6. Reset mid-MUL: drop rst_ni at cycle 5 of a MUL.
   - All outputs 0 immediately, without waiting for a clock edge.
   - After release, ADD 3+4 -> 7 with normal latency.
